// File: rtl/keypad_reader_pkg.sv
// Shared types and constants for the 4x4 keypad reader: FSM states, frame
// result kinds, key codes (row*4+col), status bit positions, digit lookup.
package kp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_KEY,
    FR_MULTI
  } kp_frame_e;

  localparam logic [3:0] KEY_BKSP  = 4'd7;
  localparam logic [3:0] KEY_CLEAR = 4'd11;
  localparam logic [3:0] KEY_STAR  = 4'd12;
  localparam logic [3:0] KEY_ENTER = 4'd14;

  localparam int ST_VALID = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_NEG   = 3;

  // Returns {is_digit, digit} for a key code.
  function automatic logic [4:0] kp_digit(input logic [3:0] code);
    case (code)
      4'd0:    kp_digit = {1'b1, 4'd1};
      4'd1:    kp_digit = {1'b1, 4'd2};
      4'd2:    kp_digit = {1'b1, 4'd3};
      4'd4:    kp_digit = {1'b1, 4'd4};
      4'd5:    kp_digit = {1'b1, 4'd5};
      4'd6:    kp_digit = {1'b1, 4'd6};
      4'd8:    kp_digit = {1'b1, 4'd7};
      4'd9:    kp_digit = {1'b1, 4'd8};
      4'd10:   kp_digit = {1'b1, 4'd9};
      4'd13:   kp_digit = {1'b1, 4'd0};
      default: kp_digit = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Row scanner: drives one row low per slot, synchronises the columns and
// reduces each 4-row frame to NONE / KEY(code) / MULTI with a done pulse.
module keypad_scan
  import kp_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic       frame_done_o,
  output logic [1:0] frame_kind_o,
  output logic [3:0] code_o
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        sync1_q, sync2_q;
  logic [1:0]        acc_n_q, acc_n_d;
  logic [3:0]        acc_code_q, acc_code_d;
  logic              done_q, done_d;
  logic [1:0]        kind_q, kind_d;
  logic [3:0]        code_q, code_d;
  logic              sample;
  logic [3:0]        lows;
  logic [2:0]        n_row;
  logic [2:0]        n_sum;
  logic [1:0]        n_tot;
  logic [1:0]        col_idx;

  assign row_o        = ~(4'b0001 << idx_q);
  assign sample       = (slot_q == SLOT_LAST);
  assign lows         = ~sync2_q;
  assign frame_done_o = done_q;
  assign frame_kind_o = kind_q;
  assign code_o       = code_q;

  // Low-column count saturates at 2: anything above one key is MULTI anyway.
  always_comb begin
    n_row = {2'b0, lows[0]} + {2'b0, lows[1]} + {2'b0, lows[2]} + {2'b0, lows[3]};
    n_sum = {1'b0, acc_n_q} + n_row;
    n_tot = (n_sum > 3'd1) ? 2'd2 : n_sum[1:0];
    casez (lows)
      4'b???1: col_idx = 2'd0;
      4'b??10: col_idx = 2'd1;
      4'b?100: col_idx = 2'd2;
      default: col_idx = 2'd3;
    endcase
  end

  always_comb begin
    slot_d     = sample ? '0 : slot_q + 1'b1;
    idx_d      = sample ? idx_q + 2'd1 : idx_q;
    acc_n_d    = acc_n_q;
    acc_code_d = acc_code_q;
    done_d     = 1'b0;
    kind_d     = kind_q;
    code_d     = code_q;
    if (sample) begin
      acc_n_d = n_tot;
      if (acc_n_q == 2'd0 && n_row == 3'd1) acc_code_d = {idx_q, col_idx};
      if (idx_q == 2'd3) begin
        done_d     = 1'b1;
        kind_d     = (n_tot == 2'd0) ? FR_NONE : (n_tot == 2'd1) ? FR_KEY : FR_MULTI;
        code_d     = acc_code_d;
        acc_n_d    = '0;
        acc_code_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q     <= '0;
      idx_q      <= '0;
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      acc_n_q    <= '0;
      acc_code_q <= '0;
      done_q     <= 1'b0;
      kind_q     <= FR_NONE;
      code_q     <= '0;
    end else begin
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      sync1_q    <= col_i;
      sync2_q    <= sync1_q;
      acc_n_q    <= acc_n_d;
      acc_code_q <= acc_code_d;
      done_q     <= done_d;
      kind_q     <= kind_d;
      code_q     <= code_d;
    end
  end

endmodule

// File: rtl/keypad_reader.sv
// Memory-mapped keypad reader: debounce FSM, decimal entry and CPU read port.
// Optional KP_NEG_ENTRY_EN: '*' toggles sign, enter commits two's complement.
module keypad_reader
  import kp_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int MAX_DIGITS = 4
) (
  input  logic        kp_clk,
  input  logic        kprst,
  output logic [3:0]  kp_row,
  input  logic [3:0]  kp_col,
  input  logic        kpread_val,
  input  logic        kpread_stat,
  output logic [15:0] kprdata
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int DG_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE);
  localparam logic [DG_W-1:0] DG_MAX  = DG_W'(MAX_DIGITS);

  kp_state_e   state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]  key_q, key_d;
  logic [15:0] entry_q, entry_d;
  logic [DG_W-1:0] digits_q, digits_d;
  logic [15:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic        neg_q, neg_d;
  logic        frame_done;
  logic [1:0]  frame_kind;
  logic [3:0]  frame_code;
  logic [4:0]  dig;
  logic [15:0] commit_val;
  logic [15:0] status;

  keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk_i        (kp_clk),
    .rst_i        (kprst),
    .col_i        (kp_col),
    .row_o        (kp_row),
    .frame_done_o (frame_done),
    .frame_kind_o (frame_kind),
    .code_o       (frame_code)
  );

  assign cnt_inc = cnt_q + 1'b1;
  assign dig     = kp_digit(key_q);

`ifdef KP_NEG_ENTRY_EN
  assign commit_val = neg_q ? (~entry_q + 16'd1) : entry_q;
`else
  assign commit_val = entry_q;
`endif

  // MULTI frames never start a press and never count toward a release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    case (state_q)
      S_IDLE: if (frame_done && frame_kind == FR_KEY) begin
        key_d   = frame_code;
        cnt_d   = DB_W'(1);
        state_d = S_DEBOUNCE;
      end
      S_DEBOUNCE: if (frame_done) begin
        if (frame_kind == FR_KEY && frame_code == key_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_LAST) state_d = S_PRESSED;
        end else if (frame_kind == FR_KEY) begin
          key_d = frame_code;
          cnt_d = DB_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESSED: begin
        state_d = S_RELEASE;
        cnt_d   = '0;
      end
      S_RELEASE: if (frame_done) begin
        if (frame_kind == FR_NONE) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_LAST) state_d = S_IDLE;
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A commit on the same edge as a value read wins over the read's clear.
  always_comb begin
    entry_d  = entry_q;
    digits_d = digits_q;
    value_d  = value_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    neg_d    = neg_q;
    if (kpread_val) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (state_q == S_PRESSED) begin
      if (dig[4]) begin
        if (digits_q < DG_MAX) begin
          entry_d  = entry_q * 16'd10 + {12'b0, dig[3:0]};
          digits_d = digits_q + 1'b1;
        end
      end else if (key_q == KEY_BKSP) begin
        if (digits_q != '0) begin
          entry_d  = entry_q / 16'd10;
          digits_d = digits_q - 1'b1;
        end
      end else if (key_q == KEY_CLEAR) begin
        entry_d  = '0;
        digits_d = '0;
        neg_d    = 1'b0;
      end else if (key_q == KEY_ENTER) begin
        value_d  = commit_val;
        valid_d  = 1'b1;
        ovr_d    = kpread_val ? ovr_q : (ovr_q | valid_q);
        entry_d  = '0;
        digits_d = '0;
        neg_d    = 1'b0;
      end
`ifdef KP_NEG_ENTRY_EN
      else if (key_q == KEY_STAR) begin
        neg_d = ~neg_q;
      end
`endif
    end
  end

  always_comb begin
    status           = '0;
    status[ST_VALID] = valid_q;
    status[ST_BUSY]  = (state_q != S_IDLE);
    status[ST_OVR]   = ovr_q;
    status[ST_NEG]   = neg_q;
    if (kpread_val)       kprdata = value_q;
    else if (kpread_stat) kprdata = status;
    else                  kprdata = '0;
  end

  always_ff @(posedge kp_clk) begin
    if (kprst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      key_q    <= '0;
      entry_q  <= '0;
      digits_q <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      entry_q  <= entry_d;
      digits_q <= digits_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: tb/tb_keypad_reader.sv
// Directed bench for keypad_reader with SCAN_DIV=4, DEBOUNCE=2 (16-clock frames).
module tb_keypad_reader;

  logic        kp_clk = 1'b0;
  logic        kprst;
  logic [3:0]  kp_row;
  logic [3:0]  kp_col;
  logic        kpread_val;
  logic        kpread_stat;
  logic [15:0] kprdata;

  logic        key_on;
  logic [1:0]  key_r, key_c;
  logic [15:0] rd;
  int          n_chk = 0;
  int          n_pass = 0;

  keypad_reader #(.SCAN_DIV(4), .DEBOUNCE(2), .MAX_DIGITS(4)) dut (
    .kp_clk      (kp_clk),
    .kprst       (kprst),
    .kp_row      (kp_row),
    .kp_col      (kp_col),
    .kpread_val  (kpread_val),
    .kpread_stat (kpread_stat),
    .kprdata     (kprdata)
  );

  always #5 kp_clk = ~kp_clk;

  // Single-key matrix model: the held key pulls its column low while its row is driven.
  assign kp_col = (key_on && (kp_row[key_r] == 1'b0)) ? ~(4'b0001 << key_c) : 4'hF;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  task automatic wait_frame();
    logic [3:0] prev;
    bit found;
    prev  = kp_row;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge kp_clk);
      if (kp_row == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = kp_row;
    end
    if (!found) begin
      n_chk++;
      $display("FAIL frame_sync: no frame start seen within 40 cycles");
    end
  endtask

  // Hold a key for 3 frames then release for 4; optionally strobe a value read on the commit edge.
  task automatic press(input logic [3:0] code, input bit rd_commit, input logic [15:0] old_val);
    wait_frame();
    key_r  = code[3:2];
    key_c  = code[1:0];
    key_on = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      @(negedge kp_clk);
      if (rd_commit && i == 33) begin
        kpread_val = 1'b1;
        #1 chk("read_on_commit_old", kprdata, old_val);
      end
      if (rd_commit && i == 34) kpread_val = 1'b0;
    end
    key_on = 1'b0;
    repeat (64) @(negedge kp_clk);
  endtask

  task automatic peek_val(output logic [15:0] d);
    @(negedge kp_clk);
    kpread_val = 1'b1;
    #1 d = kprdata;
    kpread_val = 1'b0;
  endtask

  task automatic peek_stat(output logic [15:0] d);
    @(negedge kp_clk);
    kpread_stat = 1'b1;
    #1 d = kprdata;
    kpread_stat = 1'b0;
  endtask

  task automatic read_val(output logic [15:0] d);
    @(negedge kp_clk);
    kpread_val = 1'b1;
    #1 d = kprdata;
    @(negedge kp_clk);
    kpread_val = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    kprst = 1'b1; kpread_val = 1'b0; kpread_stat = 1'b0;
    key_on = 1'b0; key_r = 2'd0; key_c = 2'd0;
    repeat (3) @(negedge kp_clk);
    kprst = 1'b0;

    // Reset while key '7' is mid-debounce and the scan is on row 1.
    wait_frame();
    key_r = 2'd2; key_c = 2'd0; key_on = 1'b1;
    repeat (20) @(negedge kp_clk);
    kprst = 1'b1;
    @(negedge kp_clk);
    kprst = 1'b0;
    chk("rst_row", {12'b0, kp_row}, 16'h000E);
    kpread_val = 1'b1;
    #1 chk("rst_val", kprdata, 16'h0000);
    kpread_stat = 1'b1;
    #1 chk("rst_both", kprdata, 16'h0000);
    kpread_val = 1'b0;
    #1 chk("rst_stat", kprdata, 16'h0000);
    kpread_stat = 1'b0;
    repeat (48) @(negedge kp_clk);
    key_on = 1'b0;
    repeat (64) @(negedge kp_clk);
    press(4'd14, 1'b0, 16'h0);
    peek_val(rd);  chk("redebounce_val", rd, 16'h0007);
    read_val(rd);

    // 1,2,3,4,# -> 1234
    press(4'd0, 1'b0, 16'h0); press(4'd1, 1'b0, 16'h0);
    press(4'd2, 1'b0, 16'h0); press(4'd4, 1'b0, 16'h0);
    press(4'd14, 1'b0, 16'h0);
    peek_stat(rd); chk("stat_after_1234", rd, 16'h0001);
    read_val(rd);  chk("val_1234", rd, 16'h04D2);
    peek_stat(rd); chk("stat_after_read", rd, 16'h0000);

    // Five 9s, fifth ignored
    for (int k = 0; k < 5; k++) press(4'd10, 1'b0, 16'h0);
    press(4'd14, 1'b0, 16'h0);
    peek_val(rd);  chk("val_9999", rd, 16'h270F);
    peek_stat(rd); chk("stat_9999", rd, 16'h0001);

    // 1,2,B,# with a value read landing on the commit edge
    press(4'd0, 1'b0, 16'h0); press(4'd1, 1'b0, 16'h0);
    press(4'd7, 1'b0, 16'h0);
    press(4'd14, 1'b1, 16'h270F);
    peek_stat(rd); chk("stat_commit_wins", rd, 16'h0001);
    read_val(rd);  chk("val_bksp", rd, 16'h0001);
    peek_stat(rd); chk("stat_cleared", rd, 16'h0000);

    // Key 5 with one-frame bounce gaps, then a stable hold
    wait_frame();
    key_r = 2'd1; key_c = 2'd1; key_on = 1'b1;
    repeat (16) @(negedge kp_clk);
    key_on = 1'b0;
    repeat (16) @(negedge kp_clk);
    key_on = 1'b1;
    repeat (16) @(negedge kp_clk);
    key_on = 1'b0;
    press(4'd5, 1'b0, 16'h0);
    press(4'd14, 1'b0, 16'h0);
    peek_val(rd);  chk("val_bounce", rd, 16'h0005);
    press(4'd14, 1'b0, 16'h0);
    peek_stat(rd); chk("stat_overrun", rd, 16'h0005);
    peek_val(rd);  chk("val_empty_enter", rd, 16'h0000);
    read_val(rd);
    peek_stat(rd); chk("stat_ovr_cleared", rd, 16'h0000);

    // 1,C,3,# -> 3
    press(4'd0, 1'b0, 16'h0); press(4'd11, 1'b0, 16'h0);
    press(4'd6 - 4'd4, 1'b0, 16'h0);
    press(4'd14, 1'b0, 16'h0);
    peek_val(rd);  chk("val_clear", rd, 16'h0003);
    read_val(rd);

    // *,4,2,#
    press(4'd12, 1'b0, 16'h0); press(4'd4, 1'b0, 16'h0);
    press(4'd1, 1'b0, 16'h0);
`ifdef KP_NEG_ENTRY_EN
    peek_stat(rd); chk("neg_bit_before", rd & 16'h0008, 16'h0008);
    press(4'd14, 1'b0, 16'h0);
    peek_val(rd);  chk("val_neg42", rd, 16'hFFD6);
`else
    peek_stat(rd); chk("neg_bit_before", rd & 16'h0008, 16'h0000);
    press(4'd14, 1'b0, 16'h0);
    peek_val(rd);  chk("val_pos42", rd, 16'h002A);
`endif
    peek_stat(rd); chk("neg_bit_after", rd & 16'h0008, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
